// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the dense-layer inference engine.
package nn_pkg;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] IN_BASE_DEF  = 10'h000;
    localparam logic [ADDR_W-1:0] W_BASE_DEF   = 10'h010;
    localparam logic [ADDR_W-1:0] OUT_BASE_DEF = 10'h090;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LDRAIN,
        MAC,
        MDRAIN,
        WRITE
    } nn_state_e;

endpackage

// File: rtl/nn_dense_engine_if.sv
// Shared-RAM port bundle: engine drives address/write data, RAM returns read data.
interface nn_dense_engine_if;
    import nn_pkg::*;

    logic [ADDR_W-1:0] nn_address;
    logic [DATA_W-1:0] nn_wd;
    logic              nn_we;
    logic [DATA_W-1:0] nn_rd;

    modport master (output nn_address, output nn_wd, output nn_we, input nn_rd);
    modport slave  (input nn_address, input nn_wd, input nn_we, output nn_rd);

endinterface

// File: rtl/nn_mac.sv
// Signed 8x8 multiply-accumulate with shift and int8 output stage.
// Define NN_DENSE_RELU_EN to apply ReLU instead of signed saturation.
module nn_mac
    import nn_pkg::*;
#(
    parameter int unsigned SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic        [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    shifted;

    assign prod = x * w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    assign shifted = acc_q >>> SHIFT;

    always_comb begin
        result = shifted[DATA_W-1:0];
`ifdef NN_DENSE_RELU_EN
        if (shifted < 0) begin
            result = 8'h00;
        end else if (shifted > 24'sd127) begin
            result = 8'h7f;
        end
`else
        if (shifted < -24'sd128) begin
            result = 8'h80;
        end else if (shifted > 24'sd127) begin
            result = 8'h7f;
        end
`endif
    end

endmodule

// File: rtl/nn_dense_engine.sv
// Dense layer engine: loads int8 inputs from RAM, computes N_OUT dot products, writes int8 results.
// Output activation selected by NN_DENSE_RELU_EN (see nn_mac).
module nn_dense_engine
    import nn_pkg::*;
#(
    parameter int unsigned        N_IN     = 16,
    parameter int unsigned        N_OUT    = 8,
    parameter logic [ADDR_W-1:0]  IN_BASE  = IN_BASE_DEF,
    parameter logic [ADDR_W-1:0]  W_BASE   = W_BASE_DEF,
    parameter logic [ADDR_W-1:0]  OUT_BASE = OUT_BASE_DEF,
    parameter int unsigned        SHIFT    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_inference,
    output logic               ready,
    nn_dense_engine_if.master  nn
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    nn_state_e          state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [OUT_W-1:0]   o_q, o_d;
    logic               ready_q, ready_d;
    logic               ld_valid_q, ld_valid_d;
    logic               mac_valid_q, mac_valid_d;
    logic [IDX_W-1:0]   idx_q;
    logic               acc_clear;
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  x_q [2**IDX_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            o_q         <= '0;
            ready_q     <= 1'b0;
            ld_valid_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            o_q         <= o_d;
            ready_q     <= ready_d;
            ld_valid_q  <= ld_valid_d;
            mac_valid_q <= mac_valid_d;
            idx_q       <= i_q;
        end
    end

    // RAM data returns one cycle after its address, so capture uses the delayed index.
    always_ff @(posedge clk) begin
        if (ld_valid_q) begin
            x_q[idx_q] <= nn.nn_rd;
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        o_d           = o_q;
        ready_d       = ready_q;
        ld_valid_d    = 1'b0;
        mac_valid_d   = 1'b0;
        acc_clear     = 1'b0;
        nn.nn_address = '0;
        nn.nn_wd      = '0;
        nn.nn_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_inference) begin
                    state_d = LOAD;
                    ready_d = 1'b0;
                    i_d     = '0;
                    o_d     = '0;
                end
            end
            LOAD: begin
                nn.nn_address = IN_BASE + ADDR_W'(i_q);
                ld_valid_d    = 1'b1;
                if (i_q == IDX_W'(N_IN - 1)) begin
                    i_d     = '0;
                    state_d = LDRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            LDRAIN: begin
                acc_clear = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                nn.nn_address = W_BASE + ADDR_W'(o_q * N_IN) + ADDR_W'(i_q);
                mac_valid_d   = 1'b1;
                if (i_q == IDX_W'(N_IN - 1)) begin
                    i_d     = '0;
                    state_d = MDRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            MDRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                nn.nn_we      = 1'b1;
                nn.nn_address = OUT_BASE + ADDR_W'(o_q);
                nn.nn_wd      = result;
                acc_clear     = 1'b1;
                if (o_q == OUT_W'(N_OUT - 1)) begin
                    o_d     = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    o_d     = o_q + 1'b1;
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = ready_q;

    nn_mac #(
        .SHIFT (SHIFT)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .en     (mac_valid_q),
        .x      ($signed(x_q[idx_q])),
        .w      ($signed(nn.nn_rd)),
        .result (result)
    );

endmodule

// File: tb/tb_nn_dense_engine.sv
// Directed bench for nn_dense_engine with a synchronous RAM model and backdoor load port.
module tb_nn_dense_engine;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic run_inference;
    logic ready;

    logic       tb_we;
    logic [9:0] tb_addr;
    logic [7:0] tb_wd;
    logic [7:0] mem [1024];
    int         wr_count = 0;
    int         checks = 0;
    int         passed = 0;
    int         lat;
    int         wc;

    nn_dense_engine_if bus ();

    nn_dense_engine dut (
        .clk           (clk),
        .reset         (reset),
        .run_inference (run_inference),
        .ready         (ready),
        .nn            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.nn_we === 1'b1) begin
            mem[bus.nn_address] <= bus.nn_wd;
            wr_count <= wr_count + 1;
        end
        if (tb_we) mem[tb_addr] <= tb_wd;
        bus.nn_rd <= mem[bus.nn_address];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [7:0] sat_ref(input int v);
        int r;
        r = v;
`ifdef NN_DENSE_RELU_EN
        if (r < 0) r = 0;
`else
        if (r < -128) r = -128;
`endif
        if (r > 127) r = 127;
        return r[7:0];
    endfunction

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_wd   = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic fill(input int base, input int n, input logic [7:0] d);
        for (int k = 0; k < n; k++) poke(10'(base + k), d);
    endtask

    task automatic run_measure(input bit hold, output int latency);
        latency = 0;
        @(negedge clk);
        run_inference = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) run_inference = 1'b0;
        check("ready_low_after_start", 32'(ready), 32'd0);
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                latency = k;
                break;
            end
        end
        run_inference = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [7:0] exp);
        for (int o = 0; o < 8; o++) check(name, 32'(mem[10'h090 + o]), 32'(exp));
    endtask

    logic [7:0] mixed_exp [8];

    initial begin
        reset         = 1'b1;
        run_inference = 1'b0;
        tb_we         = 1'b0;
        tb_addr       = '0;
        tb_wd         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_we", 32'(bus.nn_we), 32'd0);
        check("reset_addr", 32'(bus.nn_address), 32'd0);
        check("reset_wd", 32'(bus.nn_wd), 32'd0);
        check("reset_no_writes", 32'(wr_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // x=8, w=8: acc 1024 >>> 7 = 8
        fill(0, 16, 8'd8);
        fill(16, 128, 8'd8);
        fill(144, 8, 8'haa);
        run_measure(1'b0, lat);
        check("latency_basic", 32'(lat), 32'd161);
        check_outs("out_x8_w8", 8'd8);
        check("write_count", 32'(wr_count), 32'd8);
        repeat (3) @(posedge clk);
        #1 check("ready_holds", 32'(ready), 32'd1);

        // Back-to-back start while ready is high
        fill(144, 8, 8'haa);
        run_measure(1'b0, lat);
        check("latency_b2b", 32'(lat), 32'd161);
        check_outs("out_b2b", 8'd8);

        // x=8, w=-8: acc -1024 >>> 7 = -8
        fill(16, 128, 8'hf8);
        run_measure(1'b0, lat);
        check_outs("out_x8_wm8", sat_ref(-8));

        // x=127, w=127: 258064 >>> 7 = 2016 -> clamps high
        fill(0, 16, 8'd127);
        fill(16, 128, 8'd127);
        run_measure(1'b0, lat);
        check_outs("out_pos_sat", sat_ref(2016));

        // x=127, w=-128: -260096 >>> 7 = -2032 -> clamps low
        fill(16, 128, 8'h80);
        run_measure(1'b0, lat);
        check_outs("out_neg_sat", sat_ref(-2032));

        // x=1, w=-1: -16 >>> 7 floors to -1
        fill(0, 16, 8'd1);
        fill(16, 128, 8'hff);
        run_measure(1'b0, lat);
        check_outs("out_floor", sat_ref(-1));

        // x[i]=i+1 (sum 136), row o weights = o-4: floor(136*(o-4)/128)
        for (int i = 0; i < 16; i++) poke(10'(i), 8'(i + 1));
        for (int o = 0; o < 8; o++) fill(16 + o * 16, 16, 8'(o - 4));
        mixed_exp[0] = sat_ref(-5);
        mixed_exp[1] = sat_ref(-4);
        mixed_exp[2] = sat_ref(-3);
        mixed_exp[3] = sat_ref(-2);
        mixed_exp[4] = sat_ref(0);
        mixed_exp[5] = sat_ref(1);
        mixed_exp[6] = sat_ref(2);
        mixed_exp[7] = sat_ref(3);
        fill(144, 8, 8'haa);
        run_measure(1'b1, lat);
        check("latency_held", 32'(lat), 32'd161);
        for (int o = 0; o < 8; o++) check("out_mixed", 32'(mem[10'h090 + o]), 32'(mixed_exp[o]));

        // Reset at cycle 50: output 0 already written, output 1 not yet
        fill(144, 8, 8'haa);
        @(negedge clk);
        run_inference = 1'b1;
        @(posedge clk);
        #1 run_inference = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_we", 32'(bus.nn_we), 32'd0);
        check("abort_addr", 32'(bus.nn_address), 32'd0);
        wc = wr_count;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_writes", 32'(wr_count), 32'(wc));
        check("abort_out0_kept", 32'(mem[10'h090]), 32'(mixed_exp[0]));
        check("abort_out1_untouched", 32'(mem[10'h091]), 32'haa);
        @(negedge clk);
        reset = 1'b0;
        run_measure(1'b0, lat);
        check("latency_after_abort", 32'(lat), 32'd161);
        for (int o = 0; o < 8; o++) check("out_after_abort", 32'(mem[10'h090 + o]), 32'(mixed_exp[o]));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
